// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin arbiter feeding a parallel-in/serial-out shifter.
// Frames go out LSB-first with valid/last framing, followed by GAP idle cycles.
module piso_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy,
  output logic             grant_id
);

  // state    | meaning
  // ST_IDLE  | arbitrating; ready offered to the selected requester
  // ST_SHIFT | shifting the granted word out, one bit per clock
  // ST_GAP   | idle spacing after a frame before the next grant
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int BCW    = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int GCW    = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_M1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic             ptr;

  logic any_valid;
  logic sel;
  logic in_idle;
  logic in_shift;

  // Single valid requester wins outright; contention falls back to ptr.
  always_comb begin
    sel = ptr;
    if (req0_valid && !req1_valid) sel = 1'b0;
    else if (!req0_valid && req1_valid) sel = 1'b1;
  end

  assign any_valid = req0_valid | req1_valid;
  assign in_idle   = (state == ST_IDLE);
  assign in_shift  = (state == ST_SHIFT);

  // Readies are masked during reset so every output reads 0 while rst is high.
  assign req0_ready = !rst && in_idle && any_valid && !sel;
  assign req1_ready = !rst && in_idle && any_valid &&  sel;

  assign sout       = in_shift & shreg[0];
  assign sout_valid = in_shift;
  assign sout_last  = in_shift && (bit_cnt == BIT_LAST);
  assign busy       = !in_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      ptr      <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            shreg    <= sel ? req1_data : req0_data;
            grant_id <= sel;
            ptr      <= ~sel;
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg <= shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (GAP > 0) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Directed bench for piso_arb_ctrl: three instances (4/1, 4/0 and 8/1 for WIDTH/GAP)
// share clk and rst; inputs change and outputs are sampled in the low phase.
module tb_piso_arb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instance a: WIDTH=4, GAP=1
  logic       a_v0, a_v1, a_r0, a_r1, a_so, a_sv, a_sl, a_busy, a_gid;
  logic [3:0] a_d0, a_d1;
  // instance b: WIDTH=4, GAP=0
  logic       b_v0, b_v1, b_r0, b_r1, b_so, b_sv, b_sl, b_busy, b_gid;
  logic [3:0] b_d0, b_d1;
  // instance c: WIDTH=8, GAP=1
  logic       c_v0, c_v1, c_r0, c_r1, c_so, c_sv, c_sl, c_busy, c_gid;
  logic [7:0] c_d0, c_d1;

  piso_arb_ctrl #(.WIDTH(4), .GAP(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .sout(a_so), .sout_valid(a_sv), .sout_last(a_sl), .busy(a_busy), .grant_id(a_gid)
  );

  piso_arb_ctrl #(.WIDTH(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .sout(b_so), .sout_valid(b_sv), .sout_last(b_sl), .busy(b_busy), .grant_id(b_gid)
  );

  piso_arb_ctrl #(.WIDTH(8), .GAP(1)) dut_c (
    .clk(clk), .rst(rst),
    .req0_valid(c_v0), .req0_data(c_d0), .req0_ready(c_r0),
    .req1_valid(c_v1), .req1_data(c_d1), .req1_ready(c_r1),
    .sout(c_so), .sout_valid(c_sv), .sout_last(c_sl), .busy(c_busy), .grant_id(c_gid)
  );

  task automatic clear_inputs();
    a_v0 = 0; a_v1 = 0; a_d0 = '0; a_d1 = '0;
    b_v0 = 0; b_v1 = 0; b_d0 = '0; b_d1 = '0;
    c_v0 = 0; c_v1 = 0; c_d0 = '0; c_d1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_v0 = 1; a_d0 = 4'hF;
    c_v1 = 1; c_d1 = 8'hFF;
    #1;
    checks++;
    if ({a_r0, a_r1, a_so, a_sv, a_sl, a_busy, a_gid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_a outputs got=%b want=0000000", {a_r0, a_r1, a_so, a_sv, a_sl, a_busy, a_gid});
    end
    checks++;
    if ({c_r0, c_r1, c_so, c_sv, c_sl, c_busy, c_gid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_c outputs got=%b want=0000000", {c_r0, c_r1, c_so, c_sv, c_sl, c_busy, c_gid});
    end
    checks++;
    if ({b_r0, b_r1, b_so, b_sv, b_sl, b_busy, b_gid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_b outputs got=%b want=0000000", {b_r0, b_r1, b_so, b_sv, b_sl, b_busy, b_gid});
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    do_reset();
    @(negedge clk);
    a_v0 = 1; a_d0 = 4'b1011;
    #1;
    checks++;
    if (a_r0 !== 1'b1 || a_r1 !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_handshake r0=%b r1=%b busy=%b want 1 0 0", a_r0, a_r1, a_busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_v0 = 0;
      #1;
      checks++;
      if (a_so !== exp_bits[i] || a_sv !== 1'b1 || a_sl !== (i == 3) || a_gid !== 1'b0 ||
          a_r0 !== 1'b0 || a_busy !== 1'b1) begin
        errors++;
        $display("FAIL single_bit%0d so=%b sv=%b sl=%b gid=%b r0=%b busy=%b want %b 1 %b 0 0 1",
                 i, a_so, a_sv, a_sl, a_gid, a_r0, a_busy, exp_bits[i], (i == 3));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (a_busy !== 1'b1 || a_sv !== 1'b0 || a_so !== 1'b0 || a_sl !== 1'b0) begin
      errors++;
      $display("FAIL single_gap busy=%b sv=%b so=%b sl=%b want 1 0 0 0", a_busy, a_sv, a_so, a_sl);
    end
    @(negedge clk); #1;
    checks++;
    if (a_busy !== 1'b0 || a_sv !== 1'b0 || a_gid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b sv=%b gid=%b want 0 0 0", a_busy, a_sv, a_gid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] word [2];
    logic       g;
    word[0] = 4'hA;
    word[1] = 4'h5;
    do_reset();
    @(negedge clk);
    a_v0 = 1; a_d0 = 4'hA;
    a_v1 = 1; a_d1 = 4'h5;
    for (int f = 0; f < 4; f++) begin
      g = f[0];
      if (f > 0) @(negedge clk);
      #1;
      checks++;
      if (a_r0 !== ~g || a_r1 !== g || a_busy !== 1'b0 || a_sv !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle f%0d r0=%b r1=%b busy=%b sv=%b want %b %b 0 0",
                 f, a_r0, a_r1, a_busy, a_sv, ~g, g);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        checks++;
        if (a_so !== word[g][i] || a_sv !== 1'b1 || a_sl !== (i == 3) || a_gid !== g ||
            a_r0 !== 1'b0 || a_r1 !== 1'b0) begin
          errors++;
          $display("FAIL rr_f%0d_bit%0d so=%b sv=%b sl=%b gid=%b r0=%b r1=%b want %b 1 %b %b 0 0",
                   f, i, a_so, a_sv, a_sl, a_gid, a_r0, a_r1, word[g][i], (i == 3), g);
        end
      end
      @(negedge clk); #1;
      checks++;
      if (a_busy !== 1'b1 || a_sv !== 1'b0 || a_r0 !== 1'b0 || a_r1 !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap f%0d busy=%b sv=%b r0=%b r1=%b want 1 0 0 0", f, a_busy, a_sv, a_r0, a_r1);
      end
    end
    clear_inputs();
  endtask

  task automatic test_late_request();
    logic [3:0] exp_bits;
    exp_bits = 4'b0110;
    do_reset();
    @(negedge clk);
    a_v0 = 1; a_d0 = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_v0 = 0;
      if (i == 1) begin a_v1 = 1; a_d1 = 4'b1001; end
      #1;
      checks++;
      if (a_r1 !== 1'b0 || a_r0 !== 1'b0) begin
        errors++;
        $display("FAIL late_ready_c%0d r0=%b r1=%b want 0 0", i, a_r0, a_r1);
      end
      if (i < 4) begin
        checks++;
        if (a_so !== exp_bits[i] || a_sv !== 1'b1 || a_sl !== (i == 3) || a_gid !== 1'b0) begin
          errors++;
          $display("FAIL late_bit%0d so=%b sv=%b sl=%b gid=%b want %b 1 %b 0",
                   i, a_so, a_sv, a_sl, a_gid, exp_bits[i], (i == 3));
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (a_r1 !== 1'b1 || a_r0 !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL late_grant r1=%b r0=%b busy=%b want 1 0 0", a_r1, a_r0, a_busy);
    end
    @(negedge clk);
    a_v1 = 0;
    #1;
    checks++;
    if (a_gid !== 1'b1 || a_so !== 1'b1 || a_sv !== 1'b1) begin
      errors++;
      $display("FAIL late_second gid=%b so=%b sv=%b want 1 1 1", a_gid, a_so, a_sv);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_bits;
    exp_bits = 4'hA;
    do_reset();
    @(negedge clk);
    a_v0 = 1; a_d0 = 4'hA;
    a_v1 = 1; a_d1 = 4'h5;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (a_so !== 1'b0 || a_sv !== 1'b0 || a_busy !== 1'b0 || a_r0 !== 1'b0 || a_sl !== 1'b0) begin
      errors++;
      $display("FAIL async_rst so=%b sv=%b busy=%b r0=%b sl=%b want 0 0 0 0 0",
               a_so, a_sv, a_busy, a_r0, a_sl);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (a_so !== exp_bits[i] || a_sv !== 1'b1 || a_sl !== (i == 3) || a_gid !== 1'b0) begin
        errors++;
        $display("FAIL async_after_bit%0d so=%b sv=%b sl=%b gid=%b want %b 1 %b 0",
                 i, a_so, a_sv, a_sl, a_gid, exp_bits[i], (i == 3));
      end
    end
    clear_inputs();
  endtask

  task automatic test_no_gap();
    logic [3:0] exp_bits;
    exp_bits = 4'h3;
    do_reset();
    @(negedge clk);
    b_v0 = 1; b_d0 = 4'h3;
    for (int f = 0; f < 2; f++) begin
      if (f > 0) @(negedge clk);
      #1;
      checks++;
      if (b_r0 !== 1'b1 || b_sv !== 1'b0 || b_busy !== 1'b0) begin
        errors++;
        $display("FAIL nogap_idle f%0d r0=%b sv=%b busy=%b want 1 0 0", f, b_r0, b_sv, b_busy);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        checks++;
        if (b_so !== exp_bits[i] || b_sv !== 1'b1 || b_sl !== (i == 3) || b_r0 !== 1'b0) begin
          errors++;
          $display("FAIL nogap_f%0d_bit%0d so=%b sv=%b sl=%b r0=%b want %b 1 %b 0",
                   f, i, b_so, b_sv, b_sl, b_r0, exp_bits[i], (i == 3));
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_wide();
    logic [7:0] exp_bits;
    exp_bits = 8'h81;
    do_reset();
    @(negedge clk);
    c_v1 = 1; c_d1 = 8'h81;
    #1;
    checks++;
    if (c_r1 !== 1'b1 || c_r0 !== 1'b0) begin
      errors++;
      $display("FAIL wide_handshake r1=%b r0=%b want 1 0", c_r1, c_r0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c_v1 = 0;
      #1;
      checks++;
      if (c_so !== exp_bits[i] || c_sv !== 1'b1 || c_sl !== (i == 7) || c_gid !== 1'b1) begin
        errors++;
        $display("FAIL wide_bit%0d so=%b sv=%b sl=%b gid=%b want %b 1 %b 1",
                 i, c_so, c_sv, c_sl, c_gid, exp_bits[i], (i == 7));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (c_busy !== 1'b1 || c_sv !== 1'b0 || c_gid !== 1'b1) begin
      errors++;
      $display("FAIL wide_gap busy=%b sv=%b gid=%b want 1 0 1", c_busy, c_sv, c_gid);
    end
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (c_busy !== 1'b0 || c_sv !== 1'b0 || c_gid !== 1'b1) begin
        errors++;
        $display("FAIL wide_hold busy=%b sv=%b gid=%b want 0 0 1", c_busy, c_sv, c_gid);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_late_request();
    test_async_reset();
    test_no_gap();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
